// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: multi-product vending controller with coin credit, stock tracking and coin-by-coin change return.
module vend_ctrl_multi #(
    parameter int NUM_PROD = 4,
    parameter int CREDIT_W = 8,
    parameter int STOCK_W = 4,
    parameter int STOCK_INIT = 10,
    parameter int MAX_CREDIT = 200,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {8'd20, 8'd15, 8'd10, 8'd5}
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                COIN_VALID,
    input  logic [2:0]          COIN,
    input  logic                SEL_VALID,
    input  logic [2:0]          SEL,
    input  logic                CANCEL,
    input  logic                RESTOCK,
    input  logic                CHANGE_ACK,
    output logic                DISPENSE,
    output logic [2:0]          PRODUCT,
    output logic [CREDIT_W-1:0] BALANCE,
    output logic                CHANGE_VALID,
    output logic [2:0]          CHANGE_COIN,
    output logic                COIN_REJ,
    output logic                SEL_ERR,
    output logic [NUM_PROD-1:0] EMPTY,
    output logic                BUSY
);
    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    state_t              state;
    logic [CREDIT_W-1:0] credit;
    logic [STOCK_W-1:0]  stock [NUM_PROD];
    logic [3:0]          coin_val;
    logic [3:0]          chg_val;
    logic [CREDIT_W:0]   sum;
    logic                coin_ok;
    logic                sel_hit;
    logic                sel_ok;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W-1:0] credit_left;
    logic [STOCK_W-1:0]  sel_stock;

    function automatic logic [3:0] val(input logic [2:0] c);
        return c == 3'd1 ? 4'd1 : c == 3'd2 ? 4'd2 : c == 3'd3 ? 4'd5 : c == 3'd4 ? 4'd10 : 4'd0;
    endfunction

    // Greedy change: largest coin code whose value fits in the remaining credit.
    function automatic logic [2:0] big(input logic [CREDIT_W-1:0] c);
        return c >= CREDIT_W'(10) ? 3'd4 : c >= CREDIT_W'(5) ? 3'd3 :
               c >= CREDIT_W'(2) ? 3'd2 : c != '0 ? 3'd1 : 3'd0;
    endfunction

    always_comb begin
        coin_val = val(COIN);
        chg_val = val(CHANGE_COIN);
        sum = {1'b0, credit} + (CREDIT_W+1)'(coin_val);
        coin_ok = coin_val != '0 && sum <= (CREDIT_W+1)'(MAX_CREDIT);
        credit_left = credit - CREDIT_W'(chg_val);
        price = '0;
        sel_stock = '0;
        sel_hit = 1'b0;
        for (int i = 0; i < NUM_PROD; i++)
            if (SEL == 3'(i)) begin
                sel_hit = 1'b1;
                price = PRICES[i*CREDIT_W +: CREDIT_W];
                sel_stock = stock[i];
            end
        sel_ok = sel_hit && sel_stock != '0 && credit >= price;
    end

    always_comb
        for (int i = 0; i < NUM_PROD; i++)
            EMPTY[i] = stock[i] == '0;

    assign BALANCE = credit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            credit <= '0;
            for (int i = 0; i < NUM_PROD; i++)
                stock[i] <= STOCK_W'(STOCK_INIT);
            DISPENSE <= 1'b0;
            PRODUCT <= '0;
            CHANGE_VALID <= 1'b0;
            CHANGE_COIN <= '0;
            COIN_REJ <= 1'b0;
            SEL_ERR <= 1'b0;
            BUSY <= 1'b0;
        end else begin
            DISPENSE <= 1'b0;
            PRODUCT <= '0;
            COIN_REJ <= 1'b0;
            SEL_ERR <= 1'b0;
            case (state)
                IDLE, CREDIT: begin
                    // A coin losing to CANCEL or a selection is refused, not banked.
                    if (state == CREDIT && CANCEL) begin
                        state <= CHANGE;
                        BUSY <= 1'b1;
                        CHANGE_VALID <= 1'b1;
                        CHANGE_COIN <= big(credit);
                        COIN_REJ <= COIN_VALID;
                    end else if (state == CREDIT && SEL_VALID) begin
                        COIN_REJ <= COIN_VALID;
                        if (sel_ok) begin
                            credit <= credit - price;
                            for (int i = 0; i < NUM_PROD; i++)
                                if (SEL == 3'(i))
                                    stock[i] <= stock[i] - STOCK_W'(1);
                            state <= VEND;
                            BUSY <= 1'b1;
                            DISPENSE <= 1'b1;
                            PRODUCT <= SEL;
                        end else begin
                            SEL_ERR <= 1'b1;
                        end
                    end else if (COIN_VALID) begin
                        if (coin_ok) begin
                            credit <= sum[CREDIT_W-1:0];
                            state <= CREDIT;
                        end else begin
                            COIN_REJ <= 1'b1;
                        end
                    end
                    if (state == IDLE && RESTOCK)
                        for (int i = 0; i < NUM_PROD; i++)
                            stock[i] <= STOCK_W'(STOCK_INIT);
                end
                VEND: begin
                    COIN_REJ <= COIN_VALID;
                    if (credit != '0) begin
                        state <= CHANGE;
                        CHANGE_VALID <= 1'b1;
                        CHANGE_COIN <= big(credit);
                    end else begin
                        state <= IDLE;
                        BUSY <= 1'b0;
                    end
                end
                CHANGE: begin
                    COIN_REJ <= COIN_VALID;
                    if (CHANGE_ACK) begin
                        credit <= credit_left;
                        if (credit_left == '0) begin
                            state <= IDLE;
                            BUSY <= 1'b0;
                            CHANGE_VALID <= 1'b0;
                            CHANGE_COIN <= '0;
                        end else begin
                            CHANGE_COIN <= big(credit_left);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb_vend_ctrl_multi: directed stimulus against an arithmetic model of the vending rules, plus pinned literal checks.
module tb_vend_ctrl_multi;
    localparam int NP = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       COIN_VALID = 1'b0;
    logic [2:0] COIN = '0;
    logic       SEL_VALID = 1'b0;
    logic [2:0] SEL = '0;
    logic       CANCEL = 1'b0;
    logic       RESTOCK = 1'b0;
    logic       CHANGE_ACK = 1'b0;
    logic       DISPENSE;
    logic [2:0] PRODUCT;
    logic [7:0] BALANCE;
    logic       CHANGE_VALID;
    logic [2:0] CHANGE_COIN;
    logic       COIN_REJ;
    logic       SEL_ERR;
    logic [NP-1:0] EMPTY;
    logic       BUSY;

    vend_ctrl_multi dut (
        .CLK(CLK), .RST(RST), .COIN_VALID(COIN_VALID), .COIN(COIN),
        .SEL_VALID(SEL_VALID), .SEL(SEL), .CANCEL(CANCEL), .RESTOCK(RESTOCK),
        .CHANGE_ACK(CHANGE_ACK), .DISPENSE(DISPENSE), .PRODUCT(PRODUCT),
        .BALANCE(BALANCE), .CHANGE_VALID(CHANGE_VALID), .CHANGE_COIN(CHANGE_COIN),
        .COIN_REJ(COIN_REJ), .SEL_ERR(SEL_ERR), .EMPTY(EMPTY), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int price [NP] = '{5, 10, 15, 20};
    int den [4] = '{10, 5, 2, 1};
    int m_credit;
    int m_stock [NP];
    int m_prod;
    bit m_vend, m_chg, m_rej, m_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int coin_value(input logic [2:0] c);
        return c == 1 ? 1 : c == 2 ? 2 : c == 3 ? 5 : c == 4 ? 10 : 0;
    endfunction

    function automatic int largest(input int v);
        for (int i = 0; i < 4; i++)
            if (v >= den[i]) return den[i];
        return 0;
    endfunction

    function automatic int code_of(input int v);
        for (int i = 0; i < 4; i++)
            if (v == den[i]) return 4 - i;
        return 0;
    endfunction

    task automatic model_step();
        bit idle;
        int s, v;
        if (RST) begin
            m_credit = 0;
            for (int i = 0; i < NP; i++) m_stock[i] = 10;
            {m_vend, m_chg, m_rej, m_err} = '0;
            m_prod = 0;
            return;
        end
        m_rej = 0;
        m_err = 0;
        if (m_chg) begin
            m_rej = COIN_VALID;
            if (CHANGE_ACK) begin
                m_credit -= largest(m_credit);
                m_chg = m_credit > 0;
            end
        end else if (m_vend) begin
            m_rej = COIN_VALID;
            m_vend = 0;
            m_chg = m_credit > 0;
        end else begin
            idle = m_credit == 0;
            s = SEL;
            if (!idle && CANCEL) begin
                m_chg = 1;
                m_rej = COIN_VALID;
            end else if (!idle && SEL_VALID) begin
                m_rej = COIN_VALID;
                if (s < NP && m_stock[s] > 0 && m_credit >= price[s]) begin
                    m_credit -= price[s];
                    m_stock[s]--;
                    m_vend = 1;
                    m_prod = s;
                end else m_err = 1;
            end else if (COIN_VALID) begin
                v = coin_value(COIN);
                if (v == 0 || m_credit + v > 200) m_rej = 1;
                else m_credit += v;
            end
            if (idle && RESTOCK)
                for (int i = 0; i < NP; i++) m_stock[i] = 10;
        end
    endtask

    task automatic compare_all();
        logic [NP-1:0] e;
        for (int i = 0; i < NP; i++) e[i] = m_stock[i] == 0;
        chk("balance", BALANCE, m_credit);
        chk("dispense", DISPENSE, m_vend);
        if (m_vend) chk("product", PRODUCT, m_prod);
        chk("change_valid", CHANGE_VALID, m_chg);
        if (m_chg) chk("change_coin", CHANGE_COIN, code_of(largest(m_credit)));
        chk("coin_rej", COIN_REJ, m_rej);
        chk("sel_err", SEL_ERR, m_err);
        chk("busy", BUSY, m_vend || m_chg);
        chk("empty", EMPTY, e);
    endtask

    task automatic tick(input logic cv, input logic [2:0] c, input logic sv, input logic [2:0] s,
                        input logic cn, input logic rs, input logic ak);
        @(negedge CLK);
        COIN_VALID = cv; COIN = c; SEL_VALID = sv; SEL = s;
        CANCEL = cn; RESTOCK = rs; CHANGE_ACK = ak;
        @(posedge CLK);
        model_step();
        #1 compare_all();
        COIN_VALID = 0; COIN = 0; SEL_VALID = 0; SEL = 0;
        CANCEL = 0; RESTOCK = 0; CHANGE_ACK = 0;
    endtask

    task automatic coin(input logic [2:0] c); tick(1, c, 0, 0, 0, 0, 0); endtask
    task automatic sel(input logic [2:0] s); tick(0, 0, 1, s, 0, 0, 0); endtask
    task automatic cancel(); tick(0, 0, 0, 0, 1, 0, 0); endtask
    task automatic idle(); tick(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic ack(); tick(0, 0, 0, 0, 0, 0, 1); endtask

    task automatic drain();
        for (int n = 0; n < 64 && CHANGE_VALID; n++) ack();
        chk("drain_done", CHANGE_VALID, 0);
    endtask

    initial begin
        idle();
        idle();
        chk("rst_balance", BALANCE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_empty", EMPTY, 0);
        @(negedge CLK) RST = 0;

        coin(4); coin(4);
        chk("two_tens", BALANCE, 20);
        sel(1);
        chk("vend_disp", DISPENSE, 1);
        chk("vend_prod", PRODUCT, 1);
        chk("vend_bal", BALANCE, 10);
        idle();
        chk("chg_valid", CHANGE_VALID, 1);
        chk("chg_coin10", CHANGE_COIN, 4);
        ack();
        chk("chg_done", CHANGE_VALID, 0);
        chk("chg_bal0", BALANCE, 0);
        chk("chg_busy0", BUSY, 0);

        coin(3); coin(2);
        cancel();
        chk("cancel_coin5", CHANGE_COIN, 3);
        coin(1);
        chk("coin_in_change", COIN_REJ, 1);
        chk("coin_in_change_bal", BALANCE, 7);
        ack();
        chk("cancel_coin2", CHANGE_COIN, 2);
        chk("cancel_bal2", BALANCE, 2);
        ack();
        chk("cancel_idle", CHANGE_VALID, 0);
        chk("cancel_bal0", BALANCE, 0);

        coin(3);
        sel(3);
        chk("poor_sel_err", SEL_ERR, 1);
        chk("poor_sel_bal", BALANCE, 5);
        sel(7);
        chk("bad_sel_err", SEL_ERR, 1);
        cancel();
        drain();

        for (int i = 0; i < 19; i++) coin(4);
        coin(3);
        chk("bal195", BALANCE, 195);
        coin(4);
        chk("over_ceiling_rej", COIN_REJ, 1);
        chk("over_ceiling_bal", BALANCE, 195);
        coin(6);
        chk("bad_code_rej", COIN_REJ, 1);
        coin(3);
        chk("at_ceiling", BALANCE, 200);
        cancel();
        drain();

        for (int i = 0; i < 10; i++) begin
            coin(3);
            sel(0);
            idle();
        end
        chk("empty0_set", EMPTY[0], 1);
        coin(3);
        sel(0);
        chk("empty_sel_err", SEL_ERR, 1);
        tick(0, 0, 0, 0, 0, 1, 0);
        chk("restock_ignored", EMPTY[0], 1);
        cancel();
        drain();
        tick(0, 0, 0, 0, 0, 1, 0);
        chk("restock_idle", EMPTY[0], 0);

        coin(4);
        tick(1, 4, 1, 1, 0, 0, 0);
        chk("tie_coin_rej", COIN_REJ, 1);
        chk("tie_dispense", DISPENSE, 1);
        chk("tie_bal", BALANCE, 0);
        idle();
        chk("tie_idle_busy", BUSY, 0);

        coin(4); coin(3);
        cancel();
        chk("pre_rst_chg", CHANGE_VALID, 1);
        @(negedge CLK) RST = 1;
        #1;
        chk("rst_mid_bal", BALANCE, 0);
        chk("rst_mid_chg", CHANGE_VALID, 0);
        chk("rst_mid_coin", CHANGE_COIN, 0);
        chk("rst_mid_busy", BUSY, 0);
        idle();
        idle();
        @(negedge CLK) RST = 0;
        idle();
        coin(2);
        chk("post_rst_bal", BALANCE, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
